seg7_display_arbiter: RTL and testbench
=======================================

Name: seg7_display_arbiter

Overview:
- Shares the 4-digit seven-segment display between NUM_REQ independent requesters. Each requester offers a 16-bit hex value.
- Grants are round-robin. Each grant holds the display for a fixed dwell time.
- The granted value is decoded to four active-low segment patterns that feed the display scan driver's sseg0..sseg3 inputs directly.
- Sits between the application blocks (counters, ALU results, status words) and the scan driver.

Parameters:
- NUM_REQ, 2, number of requesters; legal 2..4.
- DWELL_CYCLES, 100000000, clk cycles a granted value stays displayed (1 s at 100 MHz); legal >= 2.
- CNT_W, 27, dwell counter width; must satisfy 2**CNT_W > DWELL_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; the requester holds it until acked.
- req_data  in  16*NUM_REQ  requester i value at [16*i+15:16*i]; nibble 0 is the rightmost digit.
- ack  out  NUM_REQ  one-hot, single-cycle pulse in the cycle the value is latched.
- sseg0..sseg3  out  7 each  active-low patterns, bit0=a … bit6=g; sseg0 is the rightmost digit.
- active_id  out  2  index of the last granted requester.
- busy  out  1  high while in HOLD.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, ack=0, busy=0, active_id=0.
  - sseg0..3=7'b0111111 (dash on every digit).
  - Round-robin pointer last_grant=NUM_REQ-1, so req[0] has top priority first.
  - Dwell counter=0.
- States: IDLE, HOLD.
- IDLE, no req bit set: stay in IDLE. Display keeps its last content (dashes only after reset).
- IDLE, any req bit set at a rising edge:
  - Select the first set bit searching last_grant+1, last_grant+2, … modulo NUM_REQ.
  - At that edge: latch the selected data into a 16-bit display register; set last_grant and active_id to the index; load the counter with DWELL_CYCLES-1; go to HOLD.
  - ack[idx]=1 for exactly the following cycle. New sseg values are visible in that same cycle.
- HOLD:
  - The counter decrements each cycle. req is ignored and no ack is issued.
  - When the counter is 0, return to IDLE at the next edge.
  - HOLD therefore lasts exactly DWELL_CYCLES cycles.
  - IDLE always lasts at least 1 cycle, so back-to-back grants are DWELL_CYCLES+1 cycles apart.
- Requester rules:
  - Deassert req the cycle after seeing ack, or re-request.
  - A req held continuously is re-granted only after all other pending requesters get a turn.
  - A req dropped before grant is simply not served. There is no latching of un-acked requests.
- Decode: each nibble maps combinationally from the display register to its sseg output. Encodings:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- busy=1 exactly in HOLD.
- Boundary cases:
  - req bits outside NUM_REQ do not exist.
  - With a single requester active, it is re-granted each DWELL_CYCLES+1 while it holds req.
- Reset mid-HOLD: immediate return to reset values. The display returns to dashes and no ack is issued.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: leading zero nibbles in digits 3..1 output 7'b1111111 (blank), scanning from digit 3 down until the first nonzero nibble. Digit 0 is always shown.
  - Example: 0x0040 shows "  40"; 0x0000 shows "   0".
- Undefined: all four digits are always decoded; 0x0040 shows "0040".

Decomposition:
- Shared package seg7_pkg:
  - State enum (IDLE, HOLD).
  - SEG_DASH=7'b0111111 and SEG_BLANK=7'b1111111.
  - The 16-entry hex segment constant table.
- Sub-module hex_to_seg7: purely combinational, 4-bit in, 7-bit active-low out. Instantiate it four times.

Test Plan (DWELL_CYCLES=8, NUM_REQ=2):
- Reset, no requests -> sseg0..3=0111111, busy=0, ack=0 indefinitely.
- req=01, data0=0x12AF -> ack=01 for one cycle after the sampling edge; sseg3..0=1111001,0100100,0001000,0001110; busy=1 for exactly 8 cycles.
- req=11 held constant with data0=0x1111, data1=0x2222 -> grants alternate 0,1,0,1; ack pulses 9 cycles apart; active_id toggles.
- req[1] pulsed during HOLD of requester 0 and dropped before HOLD ends -> no ack[1]; display stays on requester 0's value.
- rst asserted mid-HOLD, async to clk -> outputs return to dashes, busy=0, without waiting for a clk edge; after release, req=10 is granted on the first edge.
- With SEG7_LEADING_ZERO_BLANK_EN, data 0x0040 -> sseg3=sseg2=1111111, sseg1=0011001, sseg0=1000000. Without it -> sseg3=sseg2=1000000.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the seven-segment display arbiter.
// Segment patterns are active-low, bit0=a ... bit6=g.
package seg7_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n is the pattern for hex digit n (list runs F down to 0).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter sharing a 4-digit seven-segment display between requesters.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DWELL_CYCLES = 100000000,
  parameter int CNT_W        = 27
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [6:0]             sseg0,
  output logic [6:0]             sseg1,
  output logic [6:0]             sseg2,
  output logic [6:0]             sseg3,
  output logic [1:0]             active_id,
  output logic                   busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last_grant;
  logic [1:0]       sel;
  logic             found;
  logic             grant;
  logic [15:0]      disp;
  logic             shown;
  logic [3:0][6:0]  dec;
  logic [3:0]       blank;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = HOLD;
      HOLD:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == HOLD);
    grant = (state == IDLE) && (|req);
  end

  // Search starts just after the last winner so a held request waits its turn.
  always_comb begin
    // NOTE: defaults first so no path through the block leaves a variable unassigned (no latch).
    sel   = last_grant;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(last_grant) + k) % NUM_REQ]) begin
        found = 1'b1;
        sel   = 2'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      last_grant <= 2'(NUM_REQ - 1);
      active_id  <= '0;
      disp       <= '0;
      shown      <= 1'b0;
      ack        <= '0;
    end else begin
      ack <= '0;
      if (grant) begin
        disp       <= req_data[16*sel +: 16];
        last_grant <= sel;
        active_id  <= sel;
        cnt        <= CNT_W'(DWELL_CYCLES - 1);
        shown      <= 1'b1;
        ack        <= NUM_REQ'(1) << sel;
      end else if (busy && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  for (genvar d = 0; d < 4; d++) begin : g_dec
    hex_to_seg7 u_dec (
      .hex (disp[4*d +: 4]),
      .seg (dec[d])
    );
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit blanks only when it and every digit to its left are zero.
  assign blank[3] = (disp[15:12] == 4'h0);
  assign blank[2] = blank[3] && (disp[11:8] == 4'h0);
  assign blank[1] = blank[2] && (disp[7:4] == 4'h0);
  assign blank[0] = 1'b0;
`else
  assign blank = '0;
`endif

  always_comb begin
    sseg0 = SEG_DASH;
    sseg1 = SEG_DASH;
    sseg2 = SEG_DASH;
    sseg3 = SEG_DASH;
    if (shown) begin
      sseg0 = blank[0] ? SEG_BLANK : dec[0];
      sseg1 = blank[1] ? SEG_BLANK : dec[1];
      sseg2 = blank[2] ? SEG_BLANK : dec[2];
      sseg3 = blank[3] ? SEG_BLANK : dec[3];
    end
  end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Self-checking bench for seg7_display_arbiter against a transaction-level model.
// Honours SEG7_LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_seg7_display_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam logic [6:0] DASH = 7'b0111111;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [16*NR-1:0] req_data;
  logic [NR-1:0]   ack;
  logic [6:0]      sseg0, sseg1, sseg2, sseg3;
  logic [1:0]      active_id;
  logic            busy;

  int total = 0;
  int bad   = 0;

  seg7_display_arbiter #(
    .NUM_REQ      (NR),
    .DWELL_CYCLES (DW),
    .CNT_W        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .sseg0     (sseg0),
    .sseg1     (sseg1),
    .sseg2     (sseg2),
    .sseg3     (sseg3),
    .active_id (active_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: grants are events in time; the display is the last granted word.
  int          edge_n, next_ok, gnt_edge, m_last;
  logic [1:0]  m_id;
  logic [NR-1:0] m_ack;
  logic        m_busy;
  logic [15:0] m_disp;
  bit          m_shown;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] ref_display(input logic [15:0] v, input bit shown);
    logic [27:0] out;
    if (!shown) return {4{DASH}};
    for (int d = 0; d < 4; d++) begin
      out[7*d +: 7] = ref_seg(v[4*d +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (d > 0 && int'(v) < (1 << (4*d))) out[7*d +: 7] = 7'b1111111;
`endif
    end
    return out;
  endfunction

  task automatic model_reset();
    edge_n = 0; next_ok = 0; gnt_edge = -100; m_last = NR - 1;
    m_id = '0; m_ack = '0; m_busy = 1'b0; m_disp = '0; m_shown = 0;
  endtask

  task automatic model_edge();
    m_ack = '0;
    if (edge_n >= next_ok && req != '0) begin
      for (int k = 0; k < NR; k++) begin
        int c = (m_last + 1 + k) % NR;
        if (req[c]) begin
          m_ack[c] = 1'b1;
          m_last   = c;
          m_id     = 2'(c);
          m_disp   = req_data[16*c +: 16];
          m_shown  = 1;
          gnt_edge = edge_n;
          next_ok  = edge_n + DW + 1;
          break;
        end
      end
    end
    m_busy = (edge_n >= gnt_edge) && (edge_n < gnt_edge + DW);
    edge_n++;
  endtask

  // Drive just after a falling edge, let one rising edge pass, compare on the next falling edge.
  task automatic step(input logic [NR-1:0] r, input logic [15:0] d0, input logic [15:0] d1);
    req      = r;
    req_data = {d1, d0};
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ack", 32'(ack), 32'(m_ack));
    check("busy", 32'(busy), 32'(m_busy));
    check("active_id", 32'(active_id), 32'(m_id));
    check("sseg", 32'({sseg3, sseg2, sseg1, sseg0}), 32'(ref_display(m_disp, m_shown)));
  endtask

  int busy_n, ack1_n;
  int gnt_t[$];
  int gnt_id[$];

  initial begin
    rst = 1'b1; req = '0; req_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_sseg", 32'({sseg3, sseg2, sseg1, sseg0}), 32'({4{DASH}}));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_id", 32'(active_id), 32'd0);
    rst = 1'b0;

    // Idle with no requests: dashes persist.
    repeat (4) step(2'b00, 16'h0, 16'h0);

    // Single grant of 0x12AF and its dwell.
    step(2'b01, 16'h12AF, 16'h0);
    check("ack_12af", 32'(ack), 32'd1);
    check("sseg_12af", 32'({sseg3, sseg2, sseg1, sseg0}),
          32'({7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}));
    busy_n = int'(busy);
    for (int i = 0; i < 10; i++) begin
      step(2'b00, 16'h0, 16'h0);
      busy_n += int'(busy);
    end
    check("busy_len", 32'(busy_n), 32'(DW));

    // Both requesters held: grants alternate, DW+1 cycles apart.
    for (int i = 0; i < 40; i++) begin
      step(2'b11, 16'h1111, 16'h2222);
      if (ack != '0) begin
        gnt_t.push_back(i);
        gnt_id.push_back(ack[1] ? 1 : 0);
      end
    end
    check("rr_count", 32'(gnt_t.size()), 32'd5);
    for (int i = 0; i < gnt_t.size(); i++) begin
      check("rr_id", 32'(gnt_id[i]), 32'((i + 1) % 2));
      if (i > 0) check("rr_gap", 32'(gnt_t[i] - gnt_t[i-1]), 32'(DW + 1));
    end

    // req[1] pulsed and dropped inside requester 0's hold is never served.
    repeat (10) step(2'b00, 16'h0, 16'h0);
    step(2'b01, 16'h3456, 16'hBEEF);
    ack1_n = 0;
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 16'h0, 16'hBEEF);
      ack1_n += int'(ack[1]);
    end
    for (int i = 0; i < 10; i++) begin
      step(2'b00, 16'h0, 16'h0);
      ack1_n += int'(ack[1]);
    end
    check("dropped_ack1", 32'(ack1_n), 32'd0);
    check("dropped_disp", 32'({sseg3, sseg2, sseg1, sseg0}), 32'(ref_display(16'h3456, 1)));

    // Asynchronous reset in the middle of a hold.
    step(2'b01, 16'h9876, 16'h0);
    repeat (3) step(2'b00, 16'h0, 16'h0);
    #2 rst = 1'b1;
    #1;
    check("arst_sseg", 32'({sseg3, sseg2, sseg1, sseg0}), 32'({4{DASH}}));
    check("arst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("arst_ack", 32'(ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(2'b10, 16'h0, 16'hC0DE);
    check("arst_regrant", 32'(ack), 32'd2);

    // Leading-zero handling.
    repeat (10) step(2'b00, 16'h0, 16'h0);
    step(2'b01, 16'h0040, 16'h0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check("lz_0040", 32'({sseg3, sseg2, sseg1, sseg0}),
          32'({7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000}));
`else
    check("lz_0040", 32'({sseg3, sseg2, sseg1, sseg0}),
          32'({7'b1000000, 7'b1000000, 7'b0011001, 7'b1000000}));
`endif
    repeat (9) step(2'b00, 16'h0, 16'h0);
    step(2'b10, 16'h0, 16'h0000);
    repeat (9) step(2'b00, 16'h0, 16'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(NR'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
